// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider: FSM states and div_op encodings.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] DIV_OP_SIGNED   = 2'b01;
  localparam logic [1:0] DIV_OP_UNSIGNED = 2'b10;

  // Signedness is decided by bit 0 alone; the illegal encodings fall out of this without extra logic.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op & DIV_OP_SIGNED) != 2'b00;
  endfunction

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negation, used for operand magnitudes and for result sign fixup.
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with valid/ready handshakes and flush.
// Optional early termination for trivial operands is enabled by defining ITER_DIVIDER_EARLY_TERM_EN.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         div_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               cancel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  div_state_e r_state;
  div_state_e w_next;

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dsr;
  logic [WIDTH-1:0]   r_dvd;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_dbz;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_result;

  logic               w_signed;
  logic               w_dvd_neg;
  logic               w_dsr_neg;
  logic               w_dsr_zero;
  logic               w_accept;
  logic               w_early;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_dvd;
  logic [WIDTH-1:0]   w_abs_dsr;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_quo_step;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;

  assign w_signed   = op_is_signed(div_op);
  assign w_dvd_neg  = w_signed & dividend[WIDTH-1];
  assign w_dsr_neg  = w_signed & divisor[WIDTH-1];
  assign w_dsr_zero = (divisor == '0);
  assign w_accept   = (r_state == IDLE) && in_valid && !cancel;
  assign w_last     = (r_state == CALC) && (r_cnt == CNT_W'(WIDTH - 1));

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
    .i_val (dividend),
    .i_neg (w_dvd_neg),
    .o_val (w_abs_dvd)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dsr (
    .i_val (divisor),
    .i_neg (w_dsr_neg),
    .o_val (w_abs_dsr)
  );

`ifdef ITER_DIVIDER_EARLY_TERM_EN
  assign w_early = w_dsr_zero || (w_abs_dvd < w_abs_dsr);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: the partial remainder gets the next dividend bit, then a trial subtract.
  // The extra MSB of w_trial is the borrow; the shifted remainder is always < 2*divisor.
  assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dsr};
  assign w_fits     = !w_trial[WIDTH];
  assign w_rem_step = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_step = {r_quo[WIDTH-2:0], w_fits};

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .i_val (w_quo_step),
    .i_neg (r_qneg),
    .o_val (w_quo_fix)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val (w_rem_step),
    .i_neg (r_rneg),
    .o_val (w_rem_fix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (cancel) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_next = w_early ? DONE : CALC;
        CALC:    if (w_last) w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  assign result = r_result;

  // Divide-by-zero bypasses the fixup: the signed magnitude path would mis-sign the all-ones quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsr    <= '0;
      r_dvd    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dbz    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_rem  <= '0;
      r_quo  <= w_abs_dvd;
      r_dsr  <= w_abs_dsr;
      r_dvd  <= dividend;
      r_qneg <= w_dvd_neg ^ w_dsr_neg;
      r_rneg <= w_dvd_neg;
      r_dbz  <= w_dsr_zero;
      r_cnt  <= '0;
      if (w_early) begin
        r_result <= w_dsr_zero ? {dividend, {WIDTH{1'b1}}} : {dividend, {WIDTH{1'b0}}};
      end
    end else if ((r_state == CALC) && !cancel) begin
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= r_dbz ? {r_dvd, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus randomized operations
// against an arithmetic reference model; handles ITER_DIVIDER_EARLY_TERM_EN latency.
module tb_iter_divider;
  import div_pkg::*;

  localparam int W = 32;
`ifdef ITER_DIVIDER_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     div_op;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           in_valid;
  logic           in_ready;
  logic           cancel;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Reference: wide signed arithmetic truncates toward zero, so MIN / -1 needs no special case here.
  function automatic logic [2*W-1:0] refDiv(input logic isSigned, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    if (isSigned) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int refLatency(input logic isSigned, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ma, mb;
    ma = isSigned ? longint'($signed(a)) : longint'(a);
    mb = isSigned ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    return (EARLY && (b == '0 || ma < mb)) ? 1 : W + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic watchQuiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput(tag, 64'(seen), 64'(0));
  endtask

  // One full transaction; input noise after accept checks that only the accept-cycle values matter.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int hold, input string tag);
    logic           isSigned;
    logic [2*W-1:0] expRes;
    int             expLat;
    int             lat;
    isSigned = (op == DIV_OP_SIGNED);
    expRes   = refDiv(isSigned, a, b);
    expLat   = refLatency(isSigned, a, b);
    @(negedge clk);
    div_op    = op;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    checkOutput({tag, ".in_ready_idle"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    dividend = $urandom;
    divisor  = $urandom;
    div_op   = ($urandom_range(0, 1) != 0) ? DIV_OP_SIGNED : DIV_OP_UNSIGNED;
    if (expLat > 1) checkOutput({tag, ".in_ready_busy"}, 64'(in_ready), 64'(0));
    waitValid(lat);
    checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ".result"}, result, expRes);
    repeat (hold) begin
      @(negedge clk);
      checkOutput({tag, ".hold_valid"}, {63'(0), out_valid, in_ready}, 64'(2));
      checkOutput({tag, ".hold_result"}, result, expRes);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput({tag, ".after_handshake"}, {63'(0), out_valid, in_ready}, 64'(1));
  endtask

  initial begin
    int lat;
    logic [1:0] op;
    logic [W-1:0] a, b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    cancel    = 1'b0;
    out_ready = 1'b0;
    div_op    = DIV_OP_UNSIGNED;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.flags", {63'(0), out_valid, in_ready}, 64'(1));
    checkOutput("reset.result", result, 64'(0));
    rst = 1'b0;

    applyStimulus(DIV_OP_SIGNED,   32'hFFFF_FFF9, 32'd2,         0, "s_m7_2");
    applyStimulus(DIV_OP_UNSIGNED, 32'hFFFF_FFFF, 32'h10,        1, "u_max_16");
    applyStimulus(DIV_OP_SIGNED,   32'h8000_0000, 32'hFFFF_FFFF, 0, "s_min_m1");
    applyStimulus(DIV_OP_UNSIGNED, 32'd123,       32'd0,         0, "u_123_0");
    applyStimulus(DIV_OP_SIGNED,   32'd100,       32'd7,         5, "s_100_7");
    applyStimulus(DIV_OP_SIGNED,   32'hFFFF_FFCE, 32'd0,         0, "s_m50_0");
    applyStimulus(DIV_OP_SIGNED,   32'd7,         32'hFFFF_FFFE, 0, "s_7_m2");
    applyStimulus(DIV_OP_SIGNED,   32'hFFFF_FFFD, 32'd9,         0, "s_m3_9");

    // Flush mid-calculation, then confirm the block is reusable.
    @(negedge clk);
    div_op = DIV_OP_UNSIGNED; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_calc.flags", {63'(0), out_valid, in_ready}, 64'(1));
    watchQuiet("cancel_calc.quiet", W + 4);
    applyStimulus(DIV_OP_UNSIGNED, 32'd9, 32'd3, 0, "u_9_3");
    applyStimulus(DIV_OP_UNSIGNED, 32'd3, 32'd9, 0, "u_3_9");

    // Request presented together with cancel must be dropped.
    @(negedge clk);
    div_op = DIV_OP_UNSIGNED; dividend = 32'd50; divisor = 32'd5; in_valid = 1'b1; cancel = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; cancel = 1'b0;
    checkOutput("cancel_accept.in_ready", 64'(in_ready), 64'(1));
    watchQuiet("cancel_accept.quiet", W + 4);

    // Cancel beats out_ready in DONE.
    @(negedge clk);
    div_op = DIV_OP_UNSIGNED; dividend = 32'd20; divisor = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waitValid(lat);
    checkOutput("cancel_done.valid", 64'(out_valid), 64'(1));
    cancel = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    cancel = 1'b0; out_ready = 1'b0;
    checkOutput("cancel_done.flags", {63'(0), out_valid, in_ready}, 64'(1));

    // Reset in the middle of an operation leaks nothing.
    @(negedge clk);
    div_op = DIV_OP_SIGNED; dividend = 32'd77; divisor = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_reset.flags", {63'(0), out_valid, in_ready}, 64'(1));
    checkOutput("mid_reset.result", result, 64'(0));
    watchQuiet("mid_reset.quiet", W + 4);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) != 0) ? DIV_OP_SIGNED : DIV_OP_UNSIGNED;
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       begin a = W'($urandom_range(0, 200)); b = W'($urandom_range(1, 300)); end
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
